// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: round-robin arbiter serializing inquiry/deposit/withdraw on one shared balance
// Ports: clk; reset (async, active-low); req/op/amount per terminal;
//        grant/done one-hot; status, balance_out valid with done; busy in EXEC/RESP.
module atm_balance_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BAL_W = 32,
  parameter logic [BAL_W-1:0] INIT_BALANCE = 32'h000F4240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [BAL_W*NUM_REQ-1:0] amount,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [1:0]               status,
  output logic [BAL_W-1:0]         balance_out,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [BAL_W-1:0] balance, lamt, nbal;
  logic [BAL_W:0] sum;
  logic [IW-1:0] rr_ptr, win, sel, idx;
  logic [1:0] lop, nstat;
  // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((32'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
  end
  // Carry out of the widened sum flags a deposit that would wrap the balance.
  always_comb begin
    sum = {1'b0, balance} + {1'b0, lamt};
    nstat = lop == 2'b01 ? 2'b00 :
            lop == 2'b10 ? (sum[BAL_W] ? 2'b10 : 2'b00) :
            lop == 2'b11 ? (lamt > balance ? 2'b01 : 2'b00) : 2'b11;
    nbal = (lop == 2'b10 && !sum[BAL_W]) ? sum[BAL_W-1:0] :
           (lop == 2'b11 && lamt <= balance) ? balance - lamt : balance;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      balance <= INIT_BALANCE;
      rr_ptr <= '0;
      win <= '0;
      lop <= '0;
      lamt <= '0;
      grant <= '0;
      done <= '0;
      status <= '0;
      balance_out <= '0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: if (|req) begin
          win <= sel;
          lop <= op[2*sel +: 2];
          lamt <= amount[BAL_W*sel +: BAL_W];
          grant <= NUM_REQ'(1) << sel;
          busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          balance <= nbal;
          status <= nstat;
          balance_out <= nbal;
          done <= NUM_REQ'(1) << win;
          state <= RESP;
        end
        default: begin
          rr_ptr <= (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          grant <= '0;
          done <= '0;
          balance_out <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_atm_balance_arbiter.sv
// tb_atm_balance_arbiter: directed checks of arbitration, balance arithmetic and reset abort
module tb_atm_balance_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op = '0;
  logic [127:0] amount = '0;
  logic [3:0] grant, done, grant2, done2;
  logic [1:0] status, status2;
  logic [31:0] balance_out, bal2;
  logic busy, busy2;
  int compared = 0, mismatched = 0;
  logic [3:0] g, d;
  logic [1:0] s, s2;
  logic [31:0] bo, bo2;

  atm_balance_arbiter dut (.clk(clk), .reset(reset), .req(req), .op(op), .amount(amount),
    .grant(grant), .done(done), .status(status), .balance_out(balance_out), .busy(busy));
  atm_balance_arbiter #(.INIT_BALANCE(32'hFFFFFFF0)) dut_hi (.clk(clk), .reset(reset), .req(req),
    .op(op), .amount(amount), .grant(grant2), .done(done2), .status(status2), .balance_out(bal2),
    .busy(busy2));

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic txn(input int i, input logic [1:0] o, input logic [31:0] a,
                     output logic [3:0] g1, output logic [3:0] dn, output logic [1:0] st,
                     output logic [31:0] bl, output logic [1:0] st2, output logic [31:0] bl2);
    req = 4'(1) << i; op[2*i +: 2] = o; amount[32*i +: 32] = a;
    @(negedge clk); g1 = grant;
    @(negedge clk); dn = done; st = status; bl = balance_out; st2 = status2; bl2 = bal2;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++; if (grant !== 4'b0) begin mismatched++; $display("FAIL rst_grant: got %b want 0000", grant); end
    compared++; if (done !== 4'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0000", done); end
    compared++; if (status !== 2'b00) begin mismatched++; $display("FAIL rst_status: got %b want 00", status); end
    compared++; if (balance_out !== 32'h0) begin mismatched++; $display("FAIL rst_bal: got %h want 0", balance_out); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inquiry();
    req = 4'b0001; op[1:0] = 2'b01;
    @(negedge clk);
    compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL inq_grant: got %b want 0001", grant); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL inq_busy: got %b want 1", busy); end
    compared++; if (done !== 4'b0) begin mismatched++; $display("FAIL inq_early_done: got %b want 0000", done); end
    @(negedge clk);
    compared++; if (done !== 4'b0001) begin mismatched++; $display("FAIL inq_done: got %b want 0001", done); end
    compared++; if (status !== 2'b00) begin mismatched++; $display("FAIL inq_status: got %b want 00", status); end
    compared++; if (balance_out !== 32'h000F4240) begin mismatched++; $display("FAIL inq_bal: got %h want 000f4240", balance_out); end
    compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL inq_grant_resp: got %b want 0001", grant); end
    req = '0;
    @(negedge clk);
    compared++; if (done !== 4'b0 || grant !== 4'b0 || balance_out !== 32'h0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL inq_idle: got done %b grant %b bal %h busy %b want all 0", done, grant, balance_out, busy); end
  endtask

  task automatic test_deposit_withdraw();
    txn(1, 2'b10, 32'h100, g, d, s, bo, s2, bo2);
    compared++; if (d !== 4'b0010) begin mismatched++; $display("FAIL dep_done: got %b want 0010", d); end
    compared++; if (bo !== 32'h000F4340) begin mismatched++; $display("FAIL dep_bal: got %h want 000f4340", bo); end
    txn(2, 2'b11, 32'h000F4340, g, d, s, bo, s2, bo2);
    compared++; if (s !== 2'b00) begin mismatched++; $display("FAIL wd_all_status: got %b want 00", s); end
    compared++; if (bo !== 32'h0) begin mismatched++; $display("FAIL wd_all_bal: got %h want 0", bo); end
    txn(2, 2'b11, 32'h1, g, d, s, bo, s2, bo2);
    compared++; if (s !== 2'b01) begin mismatched++; $display("FAIL wd_insuf_status: got %b want 01", s); end
    compared++; if (bo !== 32'h0) begin mismatched++; $display("FAIL wd_insuf_bal: got %h want 0", bo); end
    compared++; if (status !== 2'b01) begin mismatched++; $display("FAIL status_hold: got %b want 01", status); end
    txn(3, 2'b10, 32'h0, g, d, s, bo, s2, bo2);
    compared++; if (s !== 2'b00 || bo !== 32'h0) begin mismatched++; $display("FAIL dep_zero: got %b/%h want 00/0", s, bo); end
  endtask

  task automatic test_overflow();
    do_reset();
    txn(0, 2'b10, 32'h20, g, d, s, bo, s2, bo2);
    compared++; if (s2 !== 2'b10) begin mismatched++; $display("FAIL ovf_status: got %b want 10", s2); end
    compared++; if (bo2 !== 32'hFFFFFFF0) begin mismatched++; $display("FAIL ovf_bal: got %h want fffffff0", bo2); end
    txn(0, 2'b00, 32'h5, g, d, s, bo, s2, bo2);
    compared++; if (s2 !== 2'b11) begin mismatched++; $display("FAIL badop_status: got %b want 11", s2); end
    compared++; if (bo2 !== 32'hFFFFFFF0) begin mismatched++; $display("FAIL badop_bal: got %h want fffffff0", bo2); end
    txn(0, 2'b10, 32'hF, g, d, s, bo, s2, bo2);
    compared++; if (s2 !== 2'b00 || bo2 !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL dep_to_max: got %b/%h want 00/ffffffff", s2, bo2); end
    txn(0, 2'b10, 32'h1, g, d, s, bo, s2, bo2);
    compared++; if (s2 !== 2'b10 || bo2 !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL dep_past_max: got %b/%h want 10/ffffffff", s2, bo2); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int order [5];
    do_reset();
    op = 8'h55; amount = '0; req = 4'hF;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      req = 4'hF;
      if (done != 4'b0) begin
        for (int j = 0; j < 4; j++) if (done[j]) begin order[n] = j; req[j] = 1'b0; end
        n++;
      end
    end
    req = '0;
    compared++; if (n !== 5) begin mismatched++; $display("FAIL rr_count: got %0d want 5", n); end
    for (int k = 0; k < n; k++) begin
      compared++; if (order[k] !== k % 4) begin mismatched++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 4); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    do_reset();
    op = 8'b0011_1000; amount = '0; amount[63:32] = 32'h10; amount[95:64] = 32'h40;
    req = 4'b0110;
    @(negedge clk);
    compared++; if (grant !== 4'b0010) begin mismatched++; $display("FAIL sim_first_grant: got %b want 0010", grant); end
    amount[63:32] = 32'h999; op[3:2] = 2'b11;
    @(negedge clk);
    compared++; if (done !== 4'b0010 || balance_out !== 32'h000F4250) begin
      mismatched++; $display("FAIL sim_latched: got %b/%h want 0010/000f4250", done, balance_out); end
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    compared++; if (grant !== 4'b0100) begin mismatched++; $display("FAIL sim_second_grant: got %b want 0100", grant); end
    @(negedge clk);
    compared++; if (done !== 4'b0100 || balance_out !== 32'h000F4210) begin
      mismatched++; $display("FAIL sim_second: got %b/%h want 0100/000f4210", done, balance_out); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    req = 4'b0001; op[1:0] = 2'b11; amount[31:0] = 32'h10;
    @(negedge clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_exec_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    compared++; if (busy !== 1'b0 || grant !== 4'b0) begin mismatched++; $display("FAIL mid_abort: got busy %b grant %b want 0/0000", busy, grant); end
    repeat (2) begin @(negedge clk); if (done != 4'b0) seen = 1'b1; end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL mid_no_done: got %b want 0", seen); end
    req = '0; reset = 1'b1;
    @(negedge clk);
    txn(0, 2'b01, 32'h0, g, d, s, bo, s2, bo2);
    compared++; if (d !== 4'b0001 || bo !== 32'h000F4240) begin mismatched++; $display("FAIL mid_restored: got %b/%h want 0001/000f4240", d, bo); end
  endtask

  initial begin
    test_reset();
    test_inquiry();
    test_deposit_withdraw();
    test_overflow();
    test_round_robin();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
